// File: rtl/embed_nios2_debug_ocimem_if.sv
// CPU-side Avalon-MM slave bus of the debug monitor memory.
// Master drives address/command/write data; slave returns read data and waitrequest.
// Ports: avs_address (MSB selects control register), avs_read/avs_write, avs_writedata,
//        avs_byteenable, avs_readdata, avs_waitrequest.
interface embed_nios2_debug_ocimem_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W:0] avs_address;
    logic            avs_read;
    logic            avs_write;
    logic [31:0]     avs_writedata;
    logic [3:0]      avs_byteenable;
    logic [31:0]     avs_readdata;
    logic            avs_waitrequest;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
        input  avs_readdata, avs_waitrequest
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
        output avs_readdata, avs_waitrequest
    );
endinterface

// File: rtl/embed_nios2_debug_ocimem.sv
// Debug monitor RAM shared by JTAG (via sysclk-stage strobes) and a CPU Avalon-MM slave; JTAG has priority.
// Latency: JTAG read -> MonDReg 2 cycles after strobe; JTAG write 1 cycle; CPU read 2 cycles, CPU write 1 cycle.
// Backpressure: CPU held by avs_waitrequest while JTAG busy/pending; JTAG strobes dropped (jtag_overrun) when pending full.
// Ports: clk/reset_n; jdo + take_* strobes (JTAG side); avs (CPU slave interface);
//        MonDReg, monitor_ready/error (sticky status), monitor_go (pulse), jtag_overrun (sticky).
module embed_nios2_debug_ocimem #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [37:0]                   jdo,
    input  logic                          take_action_ocimem_a,
    input  logic                          take_no_action_ocimem_a,
    input  logic                          take_action_ocimem_b,
    embed_nios2_debug_ocimem_if.slave     avs,
    output logic [DATA_W-1:0]             MonDReg,
    output logic                          monitor_ready,
    output logic                          monitor_error,
    output logic                          monitor_go,
    output logic                          jtag_overrun
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_J_RD,
        ST_J_CAP,
        ST_J_WR,
        ST_C_RD,
        ST_C_DONE
    } state_t;

    localparam int BE_W = DATA_W / 8;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t              state_q, state_d;
    logic                pend_vld_q, pend_vld_d;
    logic                pend_wr_q, pend_wr_d;
    logic [DATA_W-1:0]   pend_dat_q, pend_dat_d;
    logic [ADDR_W-1:0]   mon_a_q, mon_a_d;
    logic [DATA_W-1:0]   mon_d_q, mon_d_d;
    logic                ready_q, ready_d;
    logic                error_q, error_d;
    logic                go_q, go_d;
    logic                overrun_q, overrun_d;
    logic                ctl_sel_q, ctl_sel_d;

    // Monitor RAM (contents are never reset)
    logic [DATA_W-1:0]   mem [2**ADDR_W];
    logic [DATA_W-1:0]   ram_rd_q;
    logic [ADDR_W-1:0]   ram_ra;
    logic [ADDR_W-1:0]   ram_wa;
    logic [DATA_W-1:0]   ram_wd;
    logic [BE_W-1:0]     ram_be;
    logic                ram_we;

    // ------------------------------------------------------------------
    // Strobe decode: ocimem_b > action_a > no_action_a
    // ------------------------------------------------------------------
    logic strb_b, strb_a, strb_na, strb_any, strb_multi;
    logic acc, acc_a, acc_na, acc_b, a_ctl, a_rd, acc_rdwr;
    logic disp_vld, disp_wr;
    logic cpu_req, cpu_wr, cpu_rd, cpu_ctl, cpu_ok;
    logic unused_jdo;

    assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

    always_comb begin
        strb_b     = take_action_ocimem_b;
        strb_a     = take_action_ocimem_a & ~take_action_ocimem_b;
        strb_na    = take_no_action_ocimem_a & ~take_action_ocimem_a & ~take_action_ocimem_b;
        strb_any   = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
        strb_multi = (take_action_ocimem_a & take_no_action_ocimem_a)
                   | (take_action_ocimem_a & take_action_ocimem_b)
                   | (take_no_action_ocimem_a & take_action_ocimem_b);

        // The pending slot stays occupied until the JTAG op finishes, so
        // anything arriving while an op is in flight is dropped.
        acc      = strb_any & ~pend_vld_q;
        acc_b    = acc & strb_b;
        acc_a    = acc & strb_a;
        acc_na   = acc & strb_na;
        // Control commands (jdo[35]) act immediately and never occupy pending.
        a_ctl    = acc_a & jdo[35];
        a_rd     = acc_a & ~jdo[35] & jdo[34];
        acc_rdwr = acc_b | a_rd | acc_na;

        // A deferred op (queued behind a CPU read) is dispatched before a new one.
        disp_vld = pend_vld_q | acc_rdwr;
        disp_wr  = pend_vld_q ? pend_wr_q : acc_b;

        cpu_wr   = avs.avs_write;
        cpu_rd   = avs.avs_read & ~avs.avs_write;
        cpu_req  = avs.avs_read | avs.avs_write;
        cpu_ctl  = avs.avs_address[ADDR_W];
        // A same-cycle strobe also blocks the CPU so JTAG goes first.
        cpu_ok   = (state_q == ST_IDLE) & ~pend_vld_q & ~strb_any;
    end

    // ------------------------------------------------------------------
    // Next state / datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        pend_vld_d = pend_vld_q;
        pend_wr_d  = pend_wr_q;
        pend_dat_d = pend_dat_q;
        mon_a_d    = mon_a_q;
        mon_d_d    = mon_d_q;
        ready_d    = ready_q;
        error_d    = error_q;
        overrun_d  = overrun_q;
        ctl_sel_d  = ctl_sel_q;
        go_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (disp_vld) begin
                    state_d = disp_wr ? ST_J_WR : ST_J_RD;
                end else if (cpu_ok && cpu_rd) begin
                    state_d   = ST_C_RD;
                    ctl_sel_d = cpu_ctl;
                end
            end
            ST_J_RD:   state_d = ST_J_CAP;
            ST_J_CAP: begin
                state_d    = ST_IDLE;
                mon_d_d    = ram_rd_q;
                pend_vld_d = 1'b0;
            end
            ST_J_WR: begin
                state_d    = ST_IDLE;
                mon_a_d    = mon_a_q + ADDR_W'(1);
                pend_vld_d = 1'b0;
            end
            ST_C_RD:   state_d = ST_C_DONE;
            ST_C_DONE: begin
                if (disp_vld) begin
                    state_d = disp_wr ? ST_J_WR : ST_J_RD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default:   state_d = ST_IDLE;
        endcase

        // Accepted JTAG command; MonAReg updates now so a read at the
        // next cycle already sees the new address.
        if (acc_rdwr) begin
            pend_vld_d = 1'b1;
            pend_wr_d  = acc_b;
            pend_dat_d = jdo[34:3];
        end
        if (acc_a) begin
            mon_a_d = jdo[17 +: ADDR_W];
        end else if (acc_na) begin
            mon_a_d = mon_a_q + ADDR_W'(1);
        end

        if (a_ctl) begin
            ready_d   = 1'b0;
            error_d   = 1'b0;
            overrun_d = 1'b0;
            go_d      = jdo[34];
        end
        // A set from a dropped strobe wins over a same-cycle clear.
        if (strb_any && (pend_vld_q || strb_multi)) begin
            overrun_d = 1'b1;
        end

        if (cpu_ok && cpu_wr && cpu_ctl) begin
            ready_d = ready_q | avs.avs_writedata[0];
            error_d = error_q | avs.avs_writedata[1];
        end
    end

    // RAM port steering: JTAG owns the port in J_RD/J_WR; the CPU only in IDLE.
    always_comb begin
        ram_ra = (state_q == ST_J_RD) ? mon_a_q : avs.avs_address[ADDR_W-1:0];
        ram_we = 1'b0;
        ram_wa = avs.avs_address[ADDR_W-1:0];
        ram_wd = avs.avs_writedata;
        ram_be = avs.avs_byteenable;
        if (state_q == ST_J_WR) begin
            ram_we = 1'b1;
            ram_wa = mon_a_q;
            ram_wd = pend_dat_q;
            ram_be = '1;
        end else if (cpu_ok && cpu_wr && !cpu_ctl) begin
            ram_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (ram_be[i]) begin
                    mem[ram_wa][8*i +: 8] <= ram_wd[8*i +: 8];
                end
            end
        end
        ram_rd_q <= mem[ram_ra];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            pend_vld_q <= 1'b0;
            pend_wr_q  <= 1'b0;
            pend_dat_q <= '0;
            mon_a_q    <= '0;
            mon_d_q    <= '0;
            ready_q    <= 1'b0;
            error_q    <= 1'b0;
            go_q       <= 1'b0;
            overrun_q  <= 1'b0;
            ctl_sel_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_vld_q <= pend_vld_d;
            pend_wr_q  <= pend_wr_d;
            pend_dat_q <= pend_dat_d;
            mon_a_q    <= mon_a_d;
            mon_d_q    <= mon_d_d;
            ready_q    <= ready_d;
            error_q    <= error_d;
            go_q       <= go_d;
            overrun_q  <= overrun_d;
            ctl_sel_q  <= ctl_sel_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        avs.avs_readdata = '0;
        if (state_q == ST_C_RD) begin
            avs.avs_readdata = ctl_sel_q ? {30'b0, error_q, ready_q} : ram_rd_q;
        end
        // A write is done in its accept cycle; a read is released in C_RD.
        avs.avs_waitrequest = cpu_req & ~((cpu_ok & cpu_wr) | ((state_q == ST_C_RD) & cpu_rd));
    end

    assign MonDReg       = mon_d_q;
    assign monitor_ready = ready_q;
    assign monitor_error = error_q;
    assign monitor_go    = go_q;
    assign jtag_overrun  = overrun_q;

endmodule

// File: tb/tb_embed_nios2_debug_ocimem.sv
module tb_embed_nios2_debug_ocimem;

    logic        clk;
    logic        reset_n;
    logic [37:0] jdo;
    logic        take_action_ocimem_a;
    logic        take_no_action_ocimem_a;
    logic        take_action_ocimem_b;
    logic [31:0] MonDReg;
    logic        monitor_ready;
    logic        monitor_error;
    logic        monitor_go;
    logic        jtag_overrun;

    embed_nios2_debug_ocimem_if #(.ADDR_W(8)) avs();

    embed_nios2_debug_ocimem #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .avs                     (avs),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error),
        .monitor_go              (monitor_go),
        .jtag_overrun            (jtag_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [37:0] jd_a(input logic b35, input logic b34, input logic [7:0] addr);
        logic [37:0] j;
        j = '0;
        j[35] = b35;
        j[34] = b34;
        j[24:17] = addr;
        return j;
    endfunction

    function automatic logic [37:0] jd_b(input logic [31:0] d);
        logic [37:0] j;
        j = '0;
        j[34:3] = d;
        return j;
    endfunction

    // One-cycle strobe; returns #1 into the following cycle (t+1).
    task automatic jtag(input logic a, input logic na, input logic b, input logic [37:0] d);
        take_action_ocimem_a    = a;
        take_no_action_ocimem_a = na;
        take_action_ocimem_b    = b;
        jdo                     = d;
        tick();
        take_action_ocimem_a    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        take_action_ocimem_b    = 1'b0;
        jdo                     = '0;
    endtask

    task automatic cpu_wr(input logic [8:0] addr, input logic [31:0] d, input logic [3:0] be);
        bit done;
        done = 1'b0;
        avs.avs_address    = addr;
        avs.avs_writedata  = d;
        avs.avs_byteenable = be;
        avs.avs_write      = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!avs.avs_waitrequest) begin
                done = 1'b1;
                break;
            end
        end
        tick();
        avs.avs_write = 1'b0;
        if (!done) chk("cpu_wr_timeout", 32'd0, 32'd1);
    endtask

    // Optionally fires ocimem_b in the same cycle the read is first presented.
    task automatic cpu_rd(input logic [8:0] addr, input bit with_b, input logic [31:0] bdat,
                          output logic [31:0] data, output int waits);
        bit done;
        done  = 1'b0;
        waits = 0;
        data  = '0;
        avs.avs_address = addr;
        avs.avs_read    = 1'b1;
        if (with_b) begin
            take_action_ocimem_b = 1'b1;
            jdo                  = jd_b(bdat);
        end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!avs.avs_waitrequest) begin
                data = avs.avs_readdata;
                done = 1'b1;
                break;
            end
            waits++;
            tick();
            take_action_ocimem_b = 1'b0;
            jdo                  = '0;
        end
        tick();
        avs.avs_read = 1'b0;
        if (!done) chk("cpu_rd_timeout", 32'd0, 32'd1);
    endtask

    logic [31:0] rd;
    int          w;
    logic [31:0] exp_word [4];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        jdo = '0;
        take_action_ocimem_a = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        avs.avs_address = '0;
        avs.avs_read = 1'b0;
        avs.avs_write = 1'b0;
        avs.avs_writedata = '0;
        avs.avs_byteenable = '0;
        tick(); tick();
        reset_n = 1'b1;
        tick();

        // Preload and get outputs non-zero so the reset below is observable.
        cpu_wr(9'h000, 32'h1111_1111, 4'hF);
        cpu_wr(9'h0FF, 32'hFFFF_0001, 4'hF);
        cpu_wr(9'h020, 32'h5555_AAAA, 4'hF);
        cpu_wr(9'h100, 32'h0000_0003, 4'hF);
        jtag(1'b1, 1'b0, 1'b0, jd_a(1'b0, 1'b1, 8'hFF));
        tick(); tick();
        chk("pre_rst_mondreg", MonDReg, 32'hFFFF_0001);
        chk("pre_rst_ready", {31'b0, monitor_ready}, 32'd1);

        // Reset with strobes active: no write into mem[0] must happen.
        reset_n = 1'b0;
        take_action_ocimem_b = 1'b1;
        take_action_ocimem_a = 1'b1;
        jdo = jd_b(32'hBAD0_BAD0);
        tick(); tick(); tick();
        chk("rst_mondreg", MonDReg, 32'd0);
        chk("rst_ready", {31'b0, monitor_ready}, 32'd0);
        chk("rst_error", {31'b0, monitor_error}, 32'd0);
        chk("rst_go", {31'b0, monitor_go}, 32'd0);
        chk("rst_overrun", {31'b0, jtag_overrun}, 32'd0);
        chk("rst_readdata", avs.avs_readdata, 32'd0);
        chk("rst_waitreq", {31'b0, avs.avs_waitrequest}, 32'd0);
        take_action_ocimem_b = 1'b0;
        take_action_ocimem_a = 1'b0;
        jdo = '0;
        tick();
        reset_n = 1'b1;
        tick();

        // Post-reset read of addr 0: MonDReg changes only at end of t+2.
        jtag(1'b1, 1'b0, 1'b0, jd_a(1'b0, 1'b1, 8'h00));
        chk("rd0_t1", MonDReg, 32'd0);
        tick();
        chk("rd0_t2", MonDReg, 32'd0);
        tick();
        chk("rd0_t3", MonDReg, 32'h1111_1111);

        // Address load then four writes; the fourth lands at 0x13 only if MonAReg incremented to 0x13.
        exp_word[0] = 32'hA0A0_0001;
        exp_word[1] = 32'hB0B0_0002;
        exp_word[2] = 32'hC0C0_0003;
        exp_word[3] = 32'hD0D0_0004;
        jtag(1'b1, 1'b0, 1'b0, jd_a(1'b0, 1'b0, 8'h10));
        for (int i = 0; i < 4; i++) begin
            jtag(1'b0, 1'b0, 1'b1, jd_b(exp_word[i]));
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            cpu_rd(9'(16 + i), 1'b0, 32'd0, rd, w);
            chk($sformatf("wr_mem_%0d", 16 + i), rd, exp_word[i]);
        end
        chk("wr_no_overrun", {31'b0, jtag_overrun}, 32'd0);

        // MonAReg wrap 0xFF -> 0x00 on auto-increment read.
        jtag(1'b1, 1'b0, 1'b0, jd_a(1'b0, 1'b1, 8'hFF));
        tick(); tick();
        chk("wrap_rd_ff", MonDReg, 32'hFFFF_0001);
        jtag(1'b0, 1'b1, 1'b0, 38'd0);
        tick(); tick();
        chk("wrap_rd_00", MonDReg, 32'h1111_1111);

        // Control register: write-1-to-set, then JTAG clear + go pulse.
        cpu_wr(9'h100, 32'h0000_0001, 4'hF);
        chk("ctl_ready_set", {31'b0, monitor_ready}, 32'd1);
        chk("ctl_error_clr", {31'b0, monitor_error}, 32'd0);
        cpu_wr(9'h100, 32'h0000_0002, 4'hF);
        chk("ctl_error_set", {31'b0, monitor_error}, 32'd1);
        chk("ctl_ready_keep", {31'b0, monitor_ready}, 32'd1);
        cpu_rd(9'h100, 1'b0, 32'd0, rd, w);
        chk("ctl_readback", rd, 32'd3);
        tick();
        chk("go_before", {31'b0, monitor_go}, 32'd0);
        jtag(1'b1, 1'b0, 1'b0, jd_a(1'b1, 1'b1, 8'h00));
        chk("go_t1", {31'b0, monitor_go}, 32'd1);
        chk("clr_ready", {31'b0, monitor_ready}, 32'd0);
        chk("clr_error", {31'b0, monitor_error}, 32'd0);
        tick();
        chk("go_t2", {31'b0, monitor_go}, 32'd0);

        // CPU read collides with a JTAG write to the same word.
        jtag(1'b1, 1'b0, 1'b0, jd_a(1'b0, 1'b0, 8'h20));
        tick();
        cpu_rd(9'h020, 1'b1, 32'hCAFE_F00D, rd, w);
        chk("coll_readdata", rd, 32'hCAFE_F00D);
        chk("coll_waits_ge2", {31'b0, (w >= 2)}, 32'd1);
        chk("coll_no_overrun", {31'b0, jtag_overrun}, 32'd0);
        tick();

        // Second strobe during J_RD is dropped.
        jtag(1'b1, 1'b0, 1'b0, jd_a(1'b0, 1'b1, 8'h10));
        jtag(1'b0, 1'b1, 1'b0, 38'd0);
        tick();
        chk("ovr_mondreg", MonDReg, exp_word[0]);
        chk("ovr_flag", {31'b0, jtag_overrun}, 32'd1);
        jtag(1'b0, 1'b1, 1'b0, 38'd0);
        tick(); tick();
        chk("ovr_next_rd", MonDReg, exp_word[1]);
        chk("ovr_sticky", {31'b0, jtag_overrun}, 32'd1);
        jtag(1'b1, 1'b0, 1'b0, jd_a(1'b1, 1'b0, 8'h00));
        chk("ovr_cleared", {31'b0, jtag_overrun}, 32'd0);
        chk("ovr_no_go", {31'b0, monitor_go}, 32'd0);
        tick(); tick();

        // Byte-enabled CPU write and single-wait read timing.
        cpu_wr(9'h030, 32'h1234_5678, 4'hF);
        cpu_wr(9'h030, 32'h0000_AB00, 4'b0010);
        cpu_rd(9'h030, 1'b0, 32'd0, rd, w);
        chk("be_merge", rd, 32'h1234_AB78);
        chk("rd_waits", w, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
